// File: rtl/rr_fifo_arbiter_if.sv
// FIFO-bank / egress-FIFO bundle seen by the round-robin arbiter.
// master = arbiter side, slave = FIFO side.
interface rr_fifo_arbiter_if #(
  parameter int DATA_W = 6
);
  logic [3:0]          empty;
  logic [4*DATA_W-1:0] data_in;
  logic                almost_full;
  logic [3:0]          pop;
  logic                push;
  logic [DATA_W-1:0]   data_out;
  logic [1:0]          grant_idx;

  modport master (
    input  empty, data_in, almost_full,
    output pop, push, data_out, grant_idx
  );

  modport slave (
    output empty, data_in, almost_full,
    input  pop, push, data_out, grant_idx
  );
endinterface

// File: rtl/rr_fifo_arbiter.sv
// Round-robin drain of FF0..FF3 into the egress FIFO; STRICT_PRIO_EN selects fixed priority (FF0 first).
// Latency: pop is combinational, push/data_out/grant_idx follow one cycle later; 1 word/cycle.
// Backpressure: almost_full blocks new pops (in-flight push still lands); init forces pop=0 at once.
module rr_fifo_arbiter #(
  parameter int DATA_W = 6
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                init,
  input  logic [3:0]          en_mask_in,
  rr_fifo_arbiter_if.master   bus,
  output logic [2:0]          state,
  output logic                idle
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_STALL  = 3'd4
  } state_t;

  state_t            cur_st;
  state_t            nxt_st;
  logic [3:0]        en_mask;
  logic [1:0]        rr_ptr;
  logic [3:0]        cand;
  logic              req;
  logic              arb_ok;
  logic              found;
  logic [1:0]        gnt;
  logic [1:0]        idx;
  logic [3:0]        pop_c;
  logic [DATA_W-1:0] pop_dat;
  logic              push_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        gidx_q;

  assign cand   = ~bus.empty & en_mask;
  assign req    = |cand;
  // Arbitration runs in the operational states only; init wins over everything.
  assign arb_ok = !init && !bus.almost_full && req &&
                  (cur_st == ST_IDLE || cur_st == ST_ACTIVE || cur_st == ST_STALL);

  always_comb begin
    gnt   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
`ifdef STRICT_PRIO_EN
    for (int k = 3; k >= 0; k--) begin
      if (cand[k]) begin
        gnt   = 2'(k);
        found = 1'b1;
      end
    end
`else
    for (int k = 1; k <= 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && cand[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
`endif
  end

  assign pop_c   = (arb_ok && found) ? (4'b0001 << gnt) : 4'b0000;
  assign pop_dat = bus.data_in[gnt*DATA_W +: DATA_W];

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_RESET:  nxt_st = ST_INIT;
      ST_INIT:   if (!init) nxt_st = ST_IDLE;
      ST_IDLE: begin
        if (init)                  nxt_st = ST_INIT;
        else if (req)              nxt_st = bus.almost_full ? ST_STALL : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                  nxt_st = ST_INIT;
        else if (!req)             nxt_st = ST_IDLE;
        else if (bus.almost_full)  nxt_st = ST_STALL;
      end
      ST_STALL: begin
        if (init)                  nxt_st = ST_INIT;
        else if (!bus.almost_full) nxt_st = req ? ST_ACTIVE : ST_IDLE;
      end
      default:                     nxt_st = ST_RESET;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cur_st <= ST_RESET;
    end else begin
      cur_st <= nxt_st;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      en_mask <= 4'hF;
      rr_ptr  <= 2'd3;
      push_q  <= 1'b0;
      data_q  <= '0;
      gidx_q  <= 2'd0;
    end else begin
      if (cur_st == ST_INIT) begin
        en_mask <= en_mask_in;
      end
      push_q <= |pop_c;
      if (|pop_c) begin
        rr_ptr <= gnt;
        gidx_q <= gnt;
        data_q <= pop_dat;
      end
    end
  end

  assign bus.pop       = pop_c;
  assign bus.push      = push_q;
  assign bus.data_out  = data_q;
  assign bus.grant_idx = gidx_q;
  assign state         = cur_st;
  assign idle          = (cur_st == ST_IDLE);

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Bench for rr_fifo_arbiter: queue-based FIFO bank plus a scheduling reference model, random and directed traffic.
module tb_rr_fifo_arbiter;
  localparam int DW = 6;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b1;
  logic [3:0] en_mask_in = 4'hF;
  logic       af = 1'b0;
  logic [2:0] state;
  logic       idle;

  rr_fifo_arbiter_if #(.DATA_W(DW)) bus ();

  rr_fifo_arbiter #(.DATA_W(DW)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .init       (init),
    .en_mask_in (en_mask_in),
    .bus        (bus),
    .state      (state),
    .idle       (idle)
  );

  always #5 CLK = ~CLK;

  assign bus.almost_full = af;

  logic [DW-1:0] fq[4][$];
  int checks = 0;
  int errors = 0;

  // Reference model: mode 0..4 = RESET/INIT/IDLE/ACTIVE/STALL, last = index of last served FIFO.
  int            m_st = 0;
  logic [3:0]    m_mask = 4'hF;
  int            m_last = 3;
  bit            m_push = 1'b0;
  logic [DW-1:0] m_dat = '0;
  int            m_gidx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    logic [3:0]      ev;
    logic [4*DW-1:0] dv;
    ev = '0;
    dv = '0;
    for (int i = 0; i < 4; i++) begin
      ev[i] = (fq[i].size() == 0);
      if (fq[i].size() != 0) dv[i*DW +: DW] = fq[i][0];
    end
    bus.empty   = ev;
    bus.data_in = dv;
  endtask

  function automatic bit elig(input int i);
    return (fq[i].size() > 0) && m_mask[i];
  endfunction

  function automatic bit any_req();
    return elig(0) || elig(1) || elig(2) || elig(3);
  endfunction

  function automatic int pick();
    if (m_st < 2 || init || af) return -1;
`ifdef STRICT_PRIO_EN
    for (int i = 0; i < 4; i++) if (elig(i)) return i;
`else
    for (int k = 1; k <= 4; k++) if (elig((m_last + k) % 4)) return (m_last + k) % 4;
`endif
    return -1;
  endfunction

  function automatic int next_mode(input int st, input bit rq);
    if (st == 0) return 1;
    if (init) return 1;
    if (st == 1) return 2;
    if (!rq) return (st == 4 && af) ? 4 : 2;
    return af ? 4 : 3;
  endfunction

  task automatic model_reset();
    m_st = 0; m_mask = 4'hF; m_last = 3; m_push = 1'b0; m_dat = '0; m_gidx = 0;
  endtask

  // One cycle: called at a negedge with inputs set; checks, crosses the posedge, returns at next negedge.
  task automatic step();
    int  e;
    bit  rq;
    drive_fifo();
    #1;
    e  = pick();
    rq = any_req();
    chk("pop", 32'(bus.pop), (e >= 0) ? (32'd1 << e) : 32'd0);
    chk("push", 32'(bus.push), 32'(m_push));
    chk("data_out", 32'(bus.data_out), 32'(m_dat));
    chk("grant_idx", 32'(bus.grant_idx), 32'(m_gidx));
    chk("state", 32'(state), 32'(m_st));
    chk("idle", 32'(idle), 32'(m_st == 2));
    @(posedge CLK);
    if (m_st == 1) m_mask = en_mask_in;
    if (e >= 0) begin
      m_push = 1'b1; m_dat = fq[e][0]; m_gidx = e; m_last = e;
      void'(fq[e].pop_front());
    end else begin
      m_push = 1'b0;
    end
    m_st = next_mode(m_st, rq);
    @(negedge CLK);
  endtask

  task automatic do_init(input logic [3:0] mask);
    init = 1'b1; en_mask_in = mask;
    step(); step();
    init = 1'b0;
    step();
  endtask

  int gseq[$];
  int dseq[$];

  initial begin
    drive_fifo();
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pop", 32'(bus.pop), 32'd0);
    chk("rst_push", 32'(bus.push), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_gidx", 32'(bus.grant_idx), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    @(negedge CLK);
    reset = 1'b1;
    init = 1'b1; en_mask_in = 4'hF;
    step();
    step();
    init = 1'b0;
    step();
    step();
    chk("boot_idle", 32'(idle), 32'd1);

    // Two words per FIFO: expect strict rotation 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 4; i++) begin
      fq[i].push_back(6'((i << 4) | 1));
      fq[i].push_back(6'((i << 4) | 2));
    end
    for (int c = 0; c < 11; c++) begin
      step();
      if (bus.push) begin
        gseq.push_back(int'(bus.grant_idx));
        dseq.push_back(int'(bus.data_out));
      end
    end
    chk("rr_count", 32'(gseq.size()), 32'd8);
    for (int n = 0; n < gseq.size() && n < 8; n++) begin
`ifndef STRICT_PRIO_EN
      chk("rr_order", 32'(gseq[n]), 32'(n % 4));
      chk("rr_data", 32'(dseq[n]), 32'(((n % 4) << 4) | (n / 4 + 1)));
`endif
    end

    // Almost-full held for three cycles during steady traffic.
    for (int i = 0; i < 4; i++) for (int w = 0; w < 4; w++) fq[i].push_back(6'($urandom));
    step(); step(); step();
    af = 1'b1;
    step(); step(); step();
    af = 1'b0;
    for (int c = 0; c < 16; c++) step();

    // Only FF0/FF2 enabled.
    do_init(4'b0101);
    for (int i = 0; i < 4; i++) for (int w = 0; w < 3; w++) fq[i].push_back(6'($urandom));
    for (int c = 0; c < 9; c++) begin
      step();
      chk("masked_pop13", 32'(bus.pop & 4'b1010), 32'd0);
    end

    // Nothing enabled: must stay idle.
    do_init(4'b0000);
    for (int c = 0; c < 4; c++) step();
    chk("mask0_idle", 32'(idle), 32'd1);

    do_init(4'hF);
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 4) begin
        int f;
        f = $urandom_range(0, 3);
        if (fq[f].size() < 8) fq[f].push_back(6'($urandom));
      end
      af = ($urandom_range(0, 4) == 0);
      init = ($urandom_range(0, 39) == 0);
      en_mask_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step();
    end
    init = 1'b0; af = 1'b0;
    step(); step();

    // Asynchronous reset while a push is in flight.
    for (int i = 0; i < 4; i++) fq[i].push_back(6'h2A);
    begin
      int budget;
      budget = 0;
      while (!m_push && budget < 20) begin
        step();
        budget++;
      end
      chk("push_reached", 32'(m_push), 32'd1);
    end
    drive_fifo();
    #2 reset = 1'b0;
    #1;
    chk("arst_push", 32'(bus.push), 32'd0);
    chk("arst_data", 32'(bus.data_out), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_gidx", 32'(bus.grant_idx), 32'd0);
    model_reset();
    @(negedge CLK);
    reset = 1'b1;
    init = 1'b1;
    step();
    init = 1'b0;
    for (int c = 0; c < 12; c++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
